// File: rtl/taiga_uart_rx.sv
// taiga_uart_rx: UART 8N1 receiver. It deserialises the line into bytes and
// presents each byte on a valid/ready port backed by a single holding register.
// Latency: 2-cycle input synchroniser. The byte appears the cycle after the
// stop-bit sample. The line is never back-pressured; a byte that arrives while
// the holding register is full is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk, rst        - system clock and synchronous active-high reset
//   i_rx_serial     - asynchronous serial line, idles high
//   o_rx_data/o_rx_valid/i_rx_ready - received byte and its handshake
//   o_framing_err   - one-cycle pulse when the stop bit is sampled low
//   o_overrun       - sticky dropped-byte flag, cleared by i_clr_err
//   o_busy          - high whenever the FSM is not in IDLE
module taiga_uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_framing_err,
  output logic       o_overrun,
  input  logic       i_clr_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx;

  // Both synchroniser flops reset to the idle level, so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx      <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      o_rx_data     <= 8'h00;
      o_rx_valid    <= 1'b0;
      o_framing_err <= 1'b0;
      o_overrun     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_framing_err <= 1'b0;

      // Handshake and flag clear come first. A delivery or overrun event
      // assigned later in this block takes precedence over them.
      if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
      if (i_clr_err) begin
        o_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx) begin
            state  <= START;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // The line is high again at mid start bit, so the low level was a glitch.
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              // Load when the register is empty or being drained this cycle.
              // Otherwise the held byte stays and the new byte is lost.
              if (!o_rx_valid || i_rx_ready) begin
                o_rx_data  <= shreg;
                o_rx_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              state         <= WAIT_IDLE;
              o_framing_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          // Waiting for a high level prevents a break (held-low line) from
          // re-triggering a new frame.
          if (rx) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taiga_uart_rx.sv
// tb_taiga_uart_rx: directed testbench for taiga_uart_rx with CLKS_PER_BIT=4.
// The stimulus thread pushes each expected byte into a queue. A monitor pops
// from the queue and compares on every valid&ready beat.
module tb_taiga_uart_rx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       framing_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  always #5 clk = ~clk;

  taiga_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_serial  (line),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_framing_err(framing_err),
    .o_overrun    (overrun),
    .i_clr_err    (clr_err),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    line = b;
    tick(CPB);
  endtask

  // Start bit, 8 data bits LSB first, then a stop bit. The line is left high
  // on return, so consecutive calls give back-to-back frames.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_val);
    line = 1'b1;
  endtask

  // Monitor: compare every accepted byte against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_byte: got 0x%02h, expected no byte", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_byte", {24'd0, rx_data}, {24'd0, exp_byte});
      end
    end
    if (framing_err) fe_cnt++;
  end

  initial begin
    rst      = 1'b1;
    line     = 1'b1;
    rx_ready = 1'b1;
    clr_err  = 1'b0;
    tick(3);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: plain byte
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    tick(4);
    check("t1_ferr_count", fe_cnt, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);

    // 2: single-cycle glitch is rejected
    line = 1'b0;
    tick(1);
    line = 1'b1;
    tick(8);
    check("t2_busy_after_glitch", {31'd0, busy}, 32'd0);

    // 3: bad stop bit, then a good frame
    send_byte(8'hA3, 1'b0);
    tick(6);
    check("t3_ferr_count", fe_cnt, 32'd1);
    check("t3_busy_after_wait", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    tick(4);

    // 4: overrun while not ready
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    tick(4);
    check("t4_overrun_set", {31'd0, overrun}, 32'd1);
    check("t4_held_data", {24'd0, rx_data}, 32'hA5);
    check("t4_held_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick(2);
    check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("t4_valid_drained", {31'd0, rx_valid}, 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);

    // 5: back-to-back frames
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    tick(6);
    check("t5_overrun", {31'd0, overrun}, 32'd0);

    // 6: reset in the middle of 0xC7 (bits 0 and 1 already sent)
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst  = 1'b1;
    line = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(8);
    check("t6_busy_after_reset", {31'd0, busy}, 32'd0);
    check("t6_valid_after_reset", {31'd0, rx_valid}, 32'd0);
    check("t6_ferr_count", fe_cnt, 32'd1);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_ferr_count", fe_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
